// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage of the unicycle core.
//
// Holds the PC and fetches one word at a time from instruction memory over a
// req/rvalid handshake. It registers the returned word and presents it to
// decode together with its I-type immediate field. A taken branch redirects
// the PC to instr_pc + redirect_imm. A misaligned target sets a sticky error
// and halts the stage until reset.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   imem_req       fetch request, high while waiting for a word
//   imem_addr      byte address of the request (always equals pc)
//   imem_rvalid    imem_rdata is valid this cycle
//   imem_rdata     fetched instruction word
//   stall          downstream cannot consume the presented instruction
//   redirect       presented instruction is a taken branch/jump
//   redirect_imm   signed branch offset from sign_extend
//   instr_valid    instr / instr_pc / imm_i are valid
//   instr          registered instruction
//   instr_pc       address the instruction was fetched from
//   imm_i          instr[31:20], feeds sign_extend
//   fetch_err      sticky misaligned-target error
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_imm,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [11:0] imm_i,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [11:0] imm_q, imm_d;
    logic        err_q, err_d;
    logic [31:0] tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC;
            imm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
        end
    end

    // Branch target wraps modulo 2^32.
    assign tgt = ipc_q + redirect_imm;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        imm_d   = imm_q;
        err_d   = err_q;
        case (state_q)
            S_REQ: begin
                req_d = 1'b1;
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    imm_d   = imem_rdata[31:20];
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (!redirect) begin
                        pc_d    = pc_q + 32'd4;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else if (tgt[1:0] == 2'b00) begin
                        pc_d    = tgt;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        instr_d = NOP_INSTR;
                        imm_d   = NOP_INSTR[31:20];
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign imm_i       = imm_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_imm;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [11:0] imm_i;
    logic        fetch_err;

    // Second instance with a reset PC at the top of the address space.
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic [11:0] imm_i2;
    logic        fetch_err2;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_imm(redirect_imm),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .imm_i(imm_i), .fetch_err(fetch_err)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_dut2 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .stall(1'b0), .redirect(1'b0), .redirect_imm(32'h0),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
        .imm_i(imm_i2), .fetch_err(fetch_err2)
    );

    typedef struct {
        logic [31:0] word;
        int unsigned wait_n;
        int unsigned stall_n;
        logic        redir;
        logic [31:0] imm;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [11:0] imm;
    } sb_t;

    vec_t        vecs[8];
    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input vec_t v);
        sb_t e;
        check("req_before", {31'b0, imem_req}, 32'd1);
        check("addr_before", imem_addr, model_pc);
        for (int i = 0; i < int'(v.wait_n); i++) begin
            stall = 1'b1;  // must be ignored while requesting
            tick;
            check("req_wait", {31'b0, imem_req}, 32'd1);
            check("valid_wait", {31'b0, instr_valid}, 32'd0);
        end
        stall       = (v.wait_n > 0);
        imem_rvalid = 1'b1;
        imem_rdata  = v.word;
        sb_q.push_back('{v.word, model_pc, v.word[31:20]});
        tick;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        check("valid_issue", {31'b0, instr_valid}, 32'd1);
        check("req_issue", {31'b0, imem_req}, 32'd0);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check("instr", instr, e.instr);
            check("instr_pc", instr_pc, e.pc);
            check("imm_i", {20'b0, imm_i}, {20'b0, e.imm});
        end
        for (int i = 0; i < int'(v.stall_n); i++) begin
            stall        = 1'b1;
            redirect     = v.redir;
            redirect_imm = v.imm;
            imem_rvalid  = 1'b1;  // stray rvalid outside REQ is ignored
            tick;
            check("stall_instr", instr, e.instr);
            check("stall_pc", instr_pc, e.pc);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_addr", imem_addr, model_pc);
        end
        imem_rvalid  = 1'b0;
        stall        = 1'b0;
        redirect     = v.redir;
        redirect_imm = v.imm;
        tick;
        redirect     = 1'b0;
        redirect_imm = 32'h0;
        check("next_addr", imem_addr, v.exp_addr);
        check("err", {31'b0, fetch_err}, {31'b0, v.exp_err});
        check("req_next", {31'b0, imem_req}, {31'b0, ~v.exp_err});
        check("valid_next", {31'b0, instr_valid}, 32'd0);
        model_pc = v.exp_addr;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          word          wait stall redir imm            exp_addr      err
        vecs[0] = '{32'h00A0_0093, 0,  0,   1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
        vecs[1] = '{32'h1234_5678, 3,  2,   1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
        vecs[2] = '{32'hABC0_0013, 1,  1,   1'b1, 32'h0000_0038, 32'h0000_0040, 1'b0};
        vecs[3] = '{32'hFFF0_0093, 0,  0,   1'b1, 32'hFFFF_FFF0, 32'h0000_0030, 1'b0};
        vecs[4] = '{32'h8000_0067, 2,  0,   1'b1, 32'h0000_0010, 32'h0000_0040, 1'b0};
        vecs[5] = '{32'h7FF0_0013, 0,  3,   1'b1, 32'h0000_0800, 32'h0000_0840, 1'b0};
        vecs[6] = '{32'h0000_0013, 0,  0,   1'b0, 32'h0000_0000, 32'h0000_0844, 1'b0};
        vecs[7] = '{32'h0000_0063, 0,  1,   1'b1, 32'h0000_0002, 32'h0000_0844, 1'b1};

        rst          = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_imm = 32'h0;
        imem_rvalid2 = 1'b0;
        imem_rdata2  = 32'h0;
        model_pc     = 32'h0;
        tick;
        tick;

        // Reset state
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_ipc", instr_pc, 32'h0);
        check("rst_imm", {20'b0, imm_i}, 32'h0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);

        rst = 1'b0;
        #1;
        check("req_before_edge", {31'b0, imem_req}, 32'd0);
        tick;

        for (int i = 0; i < 8; i++) do_fetch(vecs[i]);

        // Halted: stays quiet and ignores memory until reset
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h00A0_0093;
            tick;
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_valid", {31'b0, instr_valid}, 32'd0);
            check("halt_instr", instr, 32'h0000_0013);
            check("halt_err", {31'b0, fetch_err}, 32'd1);
            check("halt_addr", imem_addr, 32'h0000_0844);
        end
        imem_rvalid = 1'b0;

        // Asynchronous reset from HALT, between clock edges
        #3;
        rst = 1'b1;
        #1;
        check("arst_halt_err", {31'b0, fetch_err}, 32'd0);
        check("arst_halt_addr", imem_addr, 32'h0);
        check("arst_halt_instr", instr, 32'h0000_0013);
        tick;
        rst = 1'b0;
        tick;
        check("rereq", {31'b0, imem_req}, 32'd1);
        check("rereq_addr", imem_addr, 32'h0);

        // Asynchronous reset while requesting
        #3;
        rst = 1'b1;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0093;
        tick;
        imem_rvalid = 1'b0;
        check("pre_arst_valid", {31'b0, instr_valid}, 32'd1);

        // Asynchronous reset while issuing
        #3;
        rst = 1'b1;
        #1;
        check("arst_issue_valid", {31'b0, instr_valid}, 32'd0);
        check("arst_issue_instr", instr, 32'h0000_0013);
        check("arst_issue_imm", {20'b0, imm_i}, 32'h0);
        check("arst_issue_ipc", instr_pc, 32'h0);
        check("rst2_ipc", instr_pc2, 32'hFFFF_FFFC);
        check("rst2_addr", imem_addr2, 32'hFFFF_FFFC);
        tick;
        rst = 1'b0;
        tick;

        // PC wrap-around on sequential fetch
        check("wrap_req1", {31'b0, imem_req2}, 32'd1);
        check("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
        imem_rvalid2 = 1'b1;
        imem_rdata2  = 32'h0010_0093;
        tick;
        imem_rvalid2 = 1'b0;
        check("wrap_valid", {31'b0, instr_valid2}, 32'd1);
        check("wrap_ipc", instr_pc2, 32'hFFFF_FFFC);
        check("wrap_instr", instr2, 32'h0010_0093);
        tick;
        check("wrap_req2", {31'b0, imem_req2}, 32'd1);
        check("wrap_addr2", imem_addr2, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
